// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program-memory read handshake, control inputs and decoder-facing outputs.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic              stall;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_target;
  logic [7:0]        instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;

  // Fetch unit side.
  modport master (
    output mem_addr, mem_req, instr, instr_valid, pc,
    input  mem_ack, mem_data, stall, jump_en, jump_target
  );

  // Memory / decoder / redirect side.
  modport slave (
    input  mem_addr, mem_req, instr, instr_valid, pc,
    output mem_ack, mem_data, stall, jump_en, jump_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// Grah-8 fetch stage: owns the PC, reads program memory over req/ack and
// presents one instruction byte at a time to the decoder.
module instruction_fetch #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DISCARD} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_d;
  logic [ADDR_W-1:0] jump_reg, jump_reg_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [7:0]        instr, instr_d;
  logic              mem_req, instr_valid;

  // State and datapath registers; mem_req/instr_valid are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= PC_INIT;
      jump_reg    <= '0;
      pc          <= PC_INIT;
      instr       <= 8'h00;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      fetch_pc    <= fetch_pc_d;
      jump_reg    <= jump_reg_d;
      pc          <= pc_d;
      instr       <= instr_d;
      mem_req     <= (state_d == FETCH) || (state_d == DISCARD);
      instr_valid <= (state_d == VALID);
    end
  end

  // Next-state and datapath update; jump_en outranks mem_ack and stall.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    jump_reg_d = jump_reg;
    pc_d       = pc;
    instr_d    = instr;
    unique case (state)
      IDLE: begin
        state_d = FETCH;
        if (bus.jump_en) fetch_pc_d = bus.jump_target;
      end
      FETCH: begin
        if (bus.jump_en) begin
          if (bus.mem_ack) begin
            fetch_pc_d = bus.jump_target;
          end else begin
            // Read still outstanding: park the target until memory answers.
            jump_reg_d = bus.jump_target;
            state_d    = DISCARD;
          end
        end else if (bus.mem_ack) begin
          instr_d    = bus.mem_data;
          pc_d       = fetch_pc;
          fetch_pc_d = fetch_pc + PC_ONE;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (bus.jump_en) begin
          fetch_pc_d = bus.jump_target;
          state_d    = FETCH;
        end else if (!bus.stall) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (bus.jump_en) begin
          jump_reg_d = bus.jump_target;
          if (bus.mem_ack) begin
            fetch_pc_d = bus.jump_target;
            state_d    = FETCH;
          end
        end else if (bus.mem_ack) begin
          fetch_pc_d = jump_reg;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr    = fetch_pc;
  assign bus.mem_req     = mem_req;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;
  assign bus.pc          = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory returns addr ^ 8'hA5.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  instruction_fetch_if #(.ADDR_W(8)) bus ();

  instruction_fetch #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = bus.mem_addr ^ 8'hA5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic req, input logic [7:0] addr,
                     input logic vld, input logic [7:0] ins, input logic [7:0] pcv);
    check({tag, ".mem_req"},     32'(bus.mem_req),     32'(req));
    check({tag, ".mem_addr"},    32'(bus.mem_addr),    32'(addr));
    check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(vld));
    check({tag, ".instr"},       32'(bus.instr),       32'(ins));
    check({tag, ".pc"},          32'(bus.pc),          32'(pcv));
  endtask

  initial begin
    rst             = 1'b1;
    bus.mem_ack     = 1'b0;
    bus.stall       = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_target = 8'h00;
    tick(); tick();
    chk("reset", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

    // Release: one IDLE cycle, ack there is ignored.
    rst = 1'b0;
    chk("idle", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    bus.mem_ack = 1'b1;
    tick(); chk("fetch0", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    tick(); chk("valid0", 1'b0, 8'h01, 1'b1, 8'hA5, 8'h00);
    tick(); chk("fetch1", 1'b1, 8'h01, 1'b0, 8'hA5, 8'h00);
    tick(); chk("valid1", 1'b0, 8'h02, 1'b1, 8'hA4, 8'h01);
    tick(); chk("fetch2", 1'b1, 8'h02, 1'b0, 8'hA4, 8'h01);
    tick(); chk("valid2", 1'b0, 8'h03, 1'b1, 8'hA7, 8'h02);

    // Ack delayed three cycles: request held for four.
    bus.mem_ack = 1'b0;
    tick(); chk("wait0", 1'b1, 8'h03, 1'b0, 8'hA7, 8'h02);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("wait_hold", 1'b1, 8'h03, 1'b0, 8'hA7, 8'h02);
    end
    bus.mem_ack = 1'b1;
    tick(); chk("valid3", 1'b0, 8'h04, 1'b1, 8'hA6, 8'h03);

    // Stall for five cycles.
    bus.mem_ack = 1'b0;
    bus.stall   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("stall", 1'b0, 8'h04, 1'b1, 8'hA6, 8'h03);
    end
    bus.stall = 1'b0;
    tick(); chk("unstall", 1'b1, 8'h04, 1'b0, 8'hA6, 8'h03);

    // Jump while request outstanding.
    bus.jump_en = 1'b1; bus.jump_target = 8'h40;
    tick(); chk("discard0", 1'b1, 8'h04, 1'b0, 8'hA6, 8'h03);
    bus.jump_en = 1'b0;
    tick(); chk("discard1", 1'b1, 8'h04, 1'b0, 8'hA6, 8'h03);
    bus.mem_ack = 1'b1;
    tick(); chk("redirect40", 1'b1, 8'h40, 1'b0, 8'hA6, 8'h03);

    // Two jumps before the ack: last one wins.
    bus.mem_ack = 1'b0;
    bus.jump_en = 1'b1; bus.jump_target = 8'h50;
    tick(); chk("discard50", 1'b1, 8'h40, 1'b0, 8'hA6, 8'h03);
    bus.jump_target = 8'h80;
    tick(); chk("discard80", 1'b1, 8'h40, 1'b0, 8'hA6, 8'h03);
    bus.jump_en = 1'b0; bus.mem_ack = 1'b1;
    tick(); chk("redirect80", 1'b1, 8'h80, 1'b0, 8'hA6, 8'h03);
    tick(); chk("valid80", 1'b0, 8'h81, 1'b1, 8'h25, 8'h80);

    // Jump in VALID under stall flushes the instruction.
    bus.mem_ack = 1'b0; bus.stall = 1'b1;
    bus.jump_en = 1'b1; bus.jump_target = 8'hC0;
    tick(); chk("flush", 1'b1, 8'hC0, 1'b0, 8'h25, 8'h80);

    // Jump coincident with ack in FETCH drops the data.
    bus.jump_target = 8'hFE; bus.mem_ack = 1'b1;
    tick(); chk("jump_ack", 1'b1, 8'hFE, 1'b0, 8'h25, 8'h80);

    // PC wrap at 8'hFF.
    bus.jump_en = 1'b0;
    tick(); chk("validFE", 1'b0, 8'hFF, 1'b1, 8'h5B, 8'hFE);
    bus.stall = 1'b0; bus.mem_ack = 1'b0;
    tick(); chk("fetchFF", 1'b1, 8'hFF, 1'b0, 8'h5B, 8'hFE);
    bus.mem_ack = 1'b1;
    tick(); chk("validFF", 1'b0, 8'h00, 1'b1, 8'h5A, 8'hFF);
    bus.mem_ack = 1'b0;
    tick(); chk("wrap", 1'b1, 8'h00, 1'b0, 8'h5A, 8'hFF);
    bus.mem_ack = 1'b1;
    tick(); chk("valid_w0", 1'b0, 8'h01, 1'b1, 8'hA5, 8'h00);
    bus.mem_ack = 1'b0;
    tick(); chk("fetch_w1", 1'b1, 8'h01, 1'b0, 8'hA5, 8'h00);

    // Reset mid-request drops mem_req immediately; late ack is ignored.
    rst = 1'b1;
    #1;
    chk("rst_async", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    bus.mem_ack = 1'b1;
    tick(); chk("rst_hold", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    chk("idle2", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    tick(); chk("restart", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    tick(); chk("restart_valid", 1'b0, 8'h01, 1'b1, 8'hA5, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
